// File: rtl/cs_chk_pkg.sv
// rtl/cs_chk_pkg.sv - shared state type and default widths for cs_stream_checker
package cs_chk_pkg;

  typedef enum logic [1:0] {IDLE, DUT_RST, STREAM, DONE} cs_chk_state_e;

  localparam int DEF_X_W = 8;
  localparam int DEF_Y_W = 10;
  localparam int DEF_AW  = 15;
  localparam int DEF_LAT = 9;

endpackage

// File: rtl/cs_chk_errcnt.sv
// rtl/cs_chk_errcnt.sv - saturating mismatch counter with first-error capture
// CS_CHK_CAPTURE_EN adds latching of the first mismatching dut_y and golden value.
module cs_chk_errcnt
  import cs_chk_pkg::*;
#(
  parameter int Y_W   = DEF_Y_W,
  parameter int AW    = DEF_AW,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             chk,
  input  logic [AW-1:0]    idx,
  input  logic [Y_W-1:0]   act_y,
  input  logic [Y_W-1:0]   exp_y,
  output logic [ERR_W-1:0] err_cnt,
  output logic             first_err_valid,
  output logic [AW-1:0]    first_err_idx,
  output logic [Y_W-1:0]   first_err_y,
  output logic [Y_W-1:0]   first_err_exp
);

  localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

  logic hit;
  logic first_hit;

  // Case inequality so an X/Z from the macro under test is never silently accepted.
  assign hit       = chk && (act_y !== exp_y);
  assign first_hit = hit && !first_err_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
    end else if (clr) begin
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
    end else if (hit) begin
      if (err_cnt != '1) err_cnt <= err_cnt + ERR_ONE;
      if (first_hit) begin
        first_err_valid <= 1'b1;
        first_err_idx   <= idx;
      end
    end
  end

`ifdef CS_CHK_CAPTURE_EN
  logic [Y_W-1:0] cap_y;
  logic [Y_W-1:0] cap_exp;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_y   <= '0;
      cap_exp <= '0;
    end else if (clr) begin
      cap_y   <= '0;
      cap_exp <= '0;
    end else if (first_hit) begin
      cap_y   <= act_y;
      cap_exp <= exp_y;
    end
  end

  assign first_err_y   = cap_y;
  assign first_err_exp = cap_exp;
`else
  assign first_err_y   = '0;
  assign first_err_exp = '0;
`endif

endmodule

// File: rtl/cs_stream_checker.sv
// rtl/cs_stream_checker.sv - stimulus/response self-test engine for the CS macro
// Optional first-error value capture is enabled by CS_CHK_CAPTURE_EN.
module cs_stream_checker
  import cs_chk_pkg::*;
#(
  parameter int N_PAT   = 2000,
  parameter int LAT     = DEF_LAT,
  parameter int X_W     = DEF_X_W,
  parameter int Y_W     = DEF_Y_W,
  parameter int AW      = DEF_AW,
  parameter int RST_CYC = 2,
  parameter int ERR_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [AW-1:0]    in_addr,
  input  logic [X_W-1:0]   in_data,
  output logic [AW-1:0]    gold_addr,
  input  logic [Y_W-1:0]   gold_data,
  output logic             dut_rst,
  output logic [X_W-1:0]   dut_x,
  input  logic [Y_W-1:0]   dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             first_err_valid,
  output logic [AW-1:0]    first_err_idx,
  output logic [Y_W-1:0]   first_err_y,
  output logic [Y_W-1:0]   first_err_exp
);

  localparam logic [AW-1:0] ONE       = AW'(1);
  localparam logic [AW-1:0] RST_LAST  = AW'(RST_CYC - 1);
  localparam logic [AW-1:0] IN_LAST   = AW'(N_PAT - 1);
  localparam logic [AW-1:0] GOLD_LEAD = AW'(LAT - 1);
  localparam logic [AW-1:0] GOLD_LAST = AW'(N_PAT - LAT);
  localparam logic [AW-1:0] CHK_FIRST = AW'(LAT + 1);
  localparam logic [AW-1:0] CHK_LAST  = AW'(N_PAT + 1);

  cs_chk_state_e state;
  cs_chk_state_e state_nxt;

  logic [AW-1:0] cnt;
  logic [AW-1:0] gaddr_nxt;
  logic [AW-1:0] cmp_idx;
  logic          start_ok;
  logic          run_start;
  logic          in_adv;
  logic          chk;

  // start_ok blocks a start sampled on the first edge after reset release.
  assign run_start = start && start_ok && (state == IDLE || state == DONE);
  assign in_adv    = (state == STREAM) || (state == DUT_RST && cnt == RST_LAST);
  // Stream cycle s checks gold[s-LAT-1]: two cycles of memory plus dut_x register.
  assign chk       = (state == STREAM) && (cnt >= CHK_FIRST);
  assign cmp_idx   = cnt - CHK_FIRST;
  assign gaddr_nxt = cnt - GOLD_LEAD;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (run_start) state_nxt = DUT_RST;
      DUT_RST:    if (cnt == RST_LAST) state_nxt = STREAM;
      STREAM:     if (cnt == CHK_LAST) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dut_rst = (state == IDLE) || (state == DUT_RST);
    busy    = (state == DUT_RST) || (state == STREAM);
    done    = (state == DONE);
    pass    = (state == DONE) && (err_cnt == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_ok  <= 1'b0;
      cnt       <= '0;
      in_addr   <= '0;
      gold_addr <= '0;
      dut_x     <= '0;
    end else begin
      start_ok <= 1'b1;
      if (run_start) begin
        cnt       <= '0;
        in_addr   <= '0;
        gold_addr <= '0;
      end else begin
        if (state == DUT_RST) cnt <= (cnt == RST_LAST) ? '0 : cnt + ONE;
        if (state == STREAM) begin
          cnt   <= cnt + ONE;
          dut_x <= in_data;
          if (cnt >= GOLD_LEAD)
            gold_addr <= (gaddr_nxt > GOLD_LAST) ? GOLD_LAST : gaddr_nxt;
        end
        if (in_adv && in_addr != IN_LAST) in_addr <= in_addr + ONE;
      end
    end
  end

  cs_chk_errcnt #(
    .Y_W   (Y_W),
    .AW    (AW),
    .ERR_W (ERR_W)
  ) u_errcnt (
    .clk             (clk),
    .reset           (reset),
    .clr             (run_start),
    .chk             (chk),
    .idx             (cmp_idx),
    .act_y           (dut_y),
    .exp_y           (gold_data),
    .err_cnt         (err_cnt),
    .first_err_valid (first_err_valid),
    .first_err_idx   (first_err_idx),
    .first_err_y     (first_err_y),
    .first_err_exp   (first_err_exp)
  );

endmodule

// File: tb/tb_cs_stream_checker.sv
// tb/tb_cs_stream_checker.sv - randomized self-checking bench for cs_stream_checker
module tb_cs_stream_checker;

  localparam int N       = 2000;
  localparam int LAT     = 9;
  localparam int X_W     = 8;
  localparam int Y_W     = 10;
  localparam int AW      = 15;
  localparam int RST_CYC = 2;
  localparam int ERR_W   = 4;
  localparam int T0      = RST_CYC + 1;
  localparam int NCHK    = N - LAT + 1;
  localparam int SAT     = (1 << ERR_W) - 1;
  localparam int RUN_LEN = T0 + N + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [AW-1:0]    in_addr, gold_addr, first_err_idx;
  logic [X_W-1:0]   in_data, dut_x;
  logic [Y_W-1:0]   gold_data, dut_y, first_err_y, first_err_exp;
  logic             dut_rst, busy, done, pass, first_err_valid;
  logic [ERR_W-1:0] err_cnt;

  cs_stream_checker #(
    .N_PAT(N), .LAT(LAT), .X_W(X_W), .Y_W(Y_W), .AW(AW), .RST_CYC(RST_CYC), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_addr(in_addr), .in_data(in_data),
    .gold_addr(gold_addr), .gold_data(gold_data),
    .dut_rst(dut_rst), .dut_x(dut_x), .dut_y(dut_y),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_err_valid(first_err_valid), .first_err_idx(first_err_idx),
    .first_err_y(first_err_y), .first_err_exp(first_err_exp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int sat(input int n);
    return (n > SAT) ? SAT : n;
  endfunction

  // Pattern and golden memories with one cycle of read latency.
  logic [X_W-1:0] in_mem   [N];
  logic [Y_W-1:0] gold_mem [NCHK];

  always @(posedge clk) begin
    in_data   <= (int'(in_addr) < N) ? in_mem[in_addr] : '0;
    gold_data <= (int'(gold_addr) < NCHK) ? gold_mem[gold_addr] : '0;
  end

  // Golden CS function: max plus min over the LAT-sample window starting at k.
  function automatic logic [Y_W-1:0] cs_f(input int k);
    int mx, mn;
    mx = in_mem[k];
    mn = in_mem[k];
    for (int i = 1; i < LAT; i++) begin
      if (int'(in_mem[k+i]) > mx) mx = in_mem[k+i];
      if (int'(in_mem[k+i]) < mn) mn = in_mem[k+i];
    end
    return Y_W'(mx + mn);
  endfunction

  // Behavioural CS macro: window of the last LAT X samples, cleared in reset.
  logic [X_W-1:0] win [LAT];

  always @(posedge clk) begin
    if (dut_rst) begin
      for (int i = 0; i < LAT; i++) win[i] <= '0;
    end else begin
      for (int i = 1; i < LAT; i++) win[i] <= win[i-1];
      win[0] <= dut_x;
    end
  end

  always_comb begin
    logic [X_W-1:0] mx, mn;
    mx = win[0];
    mn = win[0];
    for (int i = 1; i < LAT; i++) begin
      if (win[i] > mx) mx = win[i];
      if (win[i] < mn) mn = win[i];
    end
    dut_y = Y_W'(mx) + Y_W'(mn);
  end

  // Run-level reference: timeline position and expected error history of the current run.
  bit             m_run = 1'b0;
  bit             m_done = 1'b0;
  bit             m_armed = 1'b0;
  int             m_rc = 0;
  int             e_pre [NCHK+1];
  int             e_first_k = -1;
  logic [Y_W-1:0] e_first_y, e_first_exp;
  int             busy_cyc = 0;
  int             rst_hi = 0;

  function automatic void plan();
    logic [Y_W-1:0] y;
    e_pre[0]  = 0;
    e_first_k = -1;
    e_first_y = '0;
    e_first_exp = '0;
    for (int k = 0; k < NCHK; k++) begin
      y = cs_f(k);
      e_pre[k+1] = e_pre[k] + ((y !== gold_mem[k]) ? 1 : 0);
      if (y !== gold_mem[k] && e_first_k < 0) begin
        e_first_k   = k;
        e_first_y   = y;
        e_first_exp = gold_mem[k];
      end
    end
    busy_cyc = 0;
    rst_hi   = 0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_run   = 1'b0;
      m_done  = 1'b0;
      m_armed = 1'b0;
      m_rc    = 0;
    end else begin
      if (m_run) begin
        m_rc++;
        if (m_rc == RUN_LEN) begin
          m_run  = 1'b0;
          m_done = 1'b1;
        end
      end else if (start && m_armed) begin
        m_run  = 1'b1;
        m_done = 1'b0;
        m_rc   = 0;
        plan();
      end
      m_armed = 1'b1;
    end
  end

  task automatic cmp_err(input int n);
    int e;
    e = e_pre[n];
    chk("err_cnt", 32'(err_cnt), sat(e));
    chk("first_err_valid", 32'(first_err_valid), 32'(e > 0));
    chk("first_err_idx", 32'(first_err_idx), (e > 0) ? e_first_k : 0);
`ifdef CS_CHK_CAPTURE_EN
    chk("first_err_y", 32'(first_err_y), (e > 0) ? 32'(e_first_y) : 0);
    chk("first_err_exp", 32'(first_err_exp), (e > 0) ? 32'(e_first_exp) : 0);
`else
    chk("first_err_y", 32'(first_err_y), 0);
    chk("first_err_exp", 32'(first_err_exp), 0);
`endif
  endtask

  always @(negedge clk) begin
    if (busy) busy_cyc++;
    if (busy && dut_rst) rst_hi++;
    if (m_run) begin
      chk("dut_rst_run", 32'(dut_rst), 32'(m_rc < RST_CYC));
      chk("busy_run", 32'(busy), 1);
      chk("done_run", 32'(done), 0);
      chk("pass_run", 32'(pass), 0);
      if (m_rc >= T0) chk("dut_x", 32'(dut_x), 32'(in_mem[imin(m_rc - T0, N - 1)]));
      if (m_rc >= RST_CYC - 1) chk("in_addr", 32'(in_addr), imin(m_rc - RST_CYC + 1, N - 1));
      if (m_rc >= T0 + LAT - 1 && m_rc <= T0 + N - 1)
        chk("gold_addr", 32'(gold_addr), m_rc - T0 - LAT + 1);
      cmp_err((m_rc > T0 + LAT) ? m_rc - T0 - LAT : 0);
    end else if (m_done) begin
      chk("dut_rst_done", 32'(dut_rst), 0);
      chk("busy_done", 32'(busy), 0);
      chk("done_done", 32'(done), 1);
      chk("pass_done", 32'(pass), 32'(e_pre[NCHK] == 0));
      chk("dut_x_done", 32'(dut_x), 32'(in_mem[N-1]));
      cmp_err(NCHK);
    end else begin
      chk("dut_rst_idle", 32'(dut_rst), 1);
      chk("busy_idle", 32'(busy), 0);
      chk("done_idle", 32'(done), 0);
      chk("pass_idle", 32'(pass), 0);
      chk("dut_x_idle", 32'(dut_x), 0);
      chk("in_addr_idle", 32'(in_addr), 0);
      chk("gold_addr_idle", 32'(gold_addr), 0);
      chk("err_cnt_idle", 32'(err_cnt), 0);
      chk("first_err_valid_idle", 32'(first_err_valid), 0);
    end
  end

  task automatic wait_rc(input int target);
    for (int i = 0; i < 3000 && !(m_run && m_rc == target); i++) @(negedge clk);
    chk("rc_reached", 32'(m_run && m_rc == target), 1);
  endtask

  task automatic run_once(input int busy_k);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (busy_k >= 0) begin
      wait_rc(T0 + busy_k + LAT);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 3000 && !done; i++) @(negedge clk);
    chk("done_seen", 32'(done), 1);
  endtask

  task automatic restore_gold();
    for (int k = 0; k < NCHK; k++) gold_mem[k] = cs_f(k);
  endtask

  initial begin
    int k1, k2, k3;
    for (int i = 0; i < N; i++) in_mem[i] = X_W'($urandom_range(1, 255));
    restore_gold();

    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_at_release_ignored", 32'(busy), 0);

    // Clean run with a start pulse at compare k=100.
    run_once(100);
    chk("clean_pass", 32'(pass), 1);
    chk("clean_err", 32'(err_cnt), 0);
    chk("clean_first_valid", 32'(first_err_valid), 0);
    chk("clean_busy_len", busy_cyc, 2004);
    chk("clean_rst_hi", rst_hi, 2);

    gold_mem[37] = 10'h3FF;
    run_once(-1);
    chk("fault_err", 32'(err_cnt), 1);
    chk("fault_idx", 32'(first_err_idx), 37);
    chk("fault_pass", 32'(pass), 0);
    chk("fault_rst_hi", rst_hi, 2);
`ifdef CS_CHK_CAPTURE_EN
    chk("fault_exp", 32'(first_err_exp), 32'h3FF);
    chk("fault_y", 32'(first_err_y), 32'(cs_f(37)));
`endif

    restore_gold();
    run_once(-1);
    chk("b2b_pass", 32'(pass), 1);
    chk("b2b_err", 32'(err_cnt), 0);

    k1 = $urandom_range(0, 600);
    k2 = k1 + 1 + $urandom_range(0, 600);
    k3 = k2 + 1 + $urandom_range(0, 600);
    gold_mem[k1] ^= 10'h155;
    gold_mem[k2] ^= 10'h2AA;
    gold_mem[k3] ^= 10'h001;
    run_once(-1);
    chk("multi_err", 32'(err_cnt), 3);
    chk("multi_idx", 32'(first_err_idx), k1);

    for (int k = 0; k < NCHK; k++) gold_mem[k] = '0;
    run_once(-1);
    chk("sat_err", 32'(err_cnt), 15);
    chk("sat_idx", 32'(first_err_idx), 0);
    chk("sat_pass", 32'(pass), 0);

    // Reset mid-run at compare k=500 with an earlier error already counted.
    restore_gold();
    gold_mem[10] = 10'h3FF;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_rc(T0 + 500 + LAT);
    chk("pre_reset_err", 32'(err_cnt), 1);
    #1 reset = 1'b0;
    #1;
    chk("arst_dut_rst", 32'(dut_rst), 1);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_err", 32'(err_cnt), 0);
    chk("arst_first_valid", 32'(first_err_valid), 0);
    chk("arst_in_addr", 32'(in_addr), 0);
    chk("arst_dut_x", 32'(dut_x), 0);
    restore_gold();
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_release_ignored", 32'(busy), 0);
    run_once(-1);
    chk("post_reset_pass", 32'(pass), 1);
    chk("post_reset_err", 32'(err_cnt), 0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
